aes_stream_feeder: RTL and testbench
====================================

// Module: aes_stream_feeder
// PURPOSE
//  Upstream stage of the AES encryption top. Packs a word stream into 128-bit plaintext blocks,
//  issues a one-cycle start to the AES controller/core pair and waits for its done.
//  Then serialises the 128-bit ciphertext back out as a word stream.
//  One block is in flight at a time. Both stream sides use valid/ready.
// PARAMETERS
//  WORD_W       32   stream word width; must divide 128 (NW = 128/WORD_W words per block)
//  TIMEOUT_CYC  64   max cycles in WAIT before a timeout (used only with the option macro)
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       asynchronous, active-high reset
//  key_in           in   128     cipher key
//  key_load         in   1       latch key_in (ignored in START/WAIT)
//  s_valid          in   1       input word valid
//  s_data           in   WORD_W  input word; first word of a block = bits [127:128-WORD_W]
//  s_ready          out  1       input word accepted when s_valid & s_ready
//  m_valid          out  1       output ciphertext word valid
//  m_data           out  WORD_W  ciphertext word, MSB word first
//  m_last           out  1       high with the final word of a block
//  m_ready          in   1       downstream accepts
//  aes_start        out  1       one-cycle start pulse to encryption top
//  aes_plain_text   out  128     block to encrypt, stable from START until done is captured
//  aes_cipher_key   out  128     latched key, stable from START until done is captured
//  aes_done         in   1       encryption done
//  aes_cipher_text  in   128     result, valid while aes_done high
//  busy             out  1       high in START/WAIT/DRAIN
//  blk_count        out  16      completed blocks, wraps 0xFFFF->0
//  err              out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state=GATHER, word index=0, all outputs 0 except s_ready=1; key reg=0. Reset mid-block drops it.
//  FSM GATHER -> START -> WAIT -> DRAIN -> GATHER.
//  GATHER: s_ready=1. Each accepted word shifts into the plaintext reg, index++.
//   Accepting word NW-1 -> START next cycle.
//  START: exactly one cycle; aes_start=1, s_ready=0 -> WAIT.
//  WAIT: s_ready=0. The first cycle with aes_done=1 captures aes_cipher_text, blk_count++, -> DRAIN.
//   aes_done seen in any other state is ignored; a held-high done captures only once.
//  DRAIN: m_valid=1, m_data=current MSB word. The reg shifts on m_valid & m_ready.
//   m_last=1 on word NW-1; its handshake -> GATHER with index=0.
//   m_data is held while m_ready=0.
//  key_load in GATHER/DRAIN: key reg <= key_in next edge. Simultaneous with a word accept, both take effect.
//   key_load in START/WAIT is dropped.
//  Latency: last input word accepted at cycle t -> aes_start at t+1. Done capture -> m_valid next cycle.
//  No overlap: s_ready=0 from START until m_last handshake.
// CONFIGURATION
//  AES_FEEDER_TIMEOUT_EN defined: a counter clears on WAIT entry.
//   If TIMEOUT_CYC cycles pass with no aes_done: err<=1 (sticky until rst), block discarded,
//   blk_count unchanged, -> GATHER.
//  Not defined: no counter, err tied 0, WAIT holds indefinitely.
// STRUCTURE
//  aes_feeder_pkg: AES_BLK_W=128, state encoding (GATHER, START, WAIT, DRAIN), NW derivation.
//  Sub-module aes_word_shifter (128-bit load/shift-by-WORD_W reg). Two instances: gather side and drain side.
// TESTING
//  FIPS-197: key 000102..0f, words 00112233,44556677,8899aabb,ccddeeff; done after 10 cycles
//   -> aes_start once, m_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, m_last on 4th, blk_count=1.
//  Backpressure: m_ready toggles 1/0 each cycle during DRAIN -> words neither duplicated nor lost; s_ready=0 until m_last.
//  Done held high 5 cycles -> single capture, blk_count +1 only.
//   Spurious aes_done during GATHER -> no state change.
//  key_load asserted during WAIT with a new key -> aes_cipher_key unchanged. key_load in DRAIN -> next block uses the new key.
//  Reset asserted mid-WAIT -> all outputs at reset values; next 4 words form a fresh block.
//  With AES_FEEDER_TIMEOUT_EN, aes_done never asserted -> err=1 after 64 WAIT cycles, state GATHER, s_ready=1.

Source files
------------

// File: rtl/aes_feeder_pkg.sv
// Shared definitions for the AES stream feeder.
//   AES_BLK_W      : AES block width in bits
//   feeder_state_e : feeder FSM encoding (GATHER, START, WAIT, DRAIN)
//   num_words()    : stream words per 128-bit block for a given word width
package aes_feeder_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    StGather,
    StStart,
    StWait,
    StDrain
  } feeder_state_e;

  function automatic int unsigned num_words(input int unsigned word_w);
    return AES_BLK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// 128-bit block register that can be parallel-loaded or shifted left by one stream word.
// New words enter at the LSB end, so after NW shifts the first word sits in the MSBs.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (register clears to 0)
//   load       : parallel load of load_data (wins over shift)
//   load_data  : 128-bit value to load
//   shift      : shift left by WORD_W, shift_in fills the LSB word
//   shift_in   : incoming word
//   data       : current register contents
module aes_word_shifter
  import aes_feeder_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] load_data,
  input  logic                 shift,
  input  logic [WORD_W-1:0]    shift_in,
  output logic [AES_BLK_W-1:0] data
);

  logic [AES_BLK_W-1:0] data_q, data_d, shifted;

  if (WORD_W == AES_BLK_W) begin : g_full_word
    assign shifted = shift_in;
  end else begin : g_part_word
    assign shifted = {data_q[AES_BLK_W-WORD_W-1:0], shift_in};
  end

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/aes_stream_feeder.sv
// Packs a valid/ready word stream into 128-bit plaintext blocks, starts the AES core with a
// one-cycle pulse, waits for done, then streams the ciphertext back out MSB word first.
// One block in flight at a time.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   key_in, key_load              : key and load strobe (dropped while START/WAIT)
//   s_valid, s_data, s_ready      : input word stream
//   m_valid, m_data, m_last, m_ready : output ciphertext stream, m_last on final word
//   aes_start, aes_plain_text, aes_cipher_key : request to the AES core
//   aes_done, aes_cipher_text     : AES core result
//   busy                          : high in START/WAIT/DRAIN
//   blk_count                     : completed blocks (wrapping)
//   err                           : sticky WAIT timeout flag
// Option macro AES_FEEDER_TIMEOUT_EN: abandon a block after TIMEOUT_CYC WAIT cycles without
// aes_done and set err; without it err is 0 and WAIT holds indefinitely.
module aes_stream_feeder
  import aes_feeder_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic                 key_load,
  input  logic                 s_valid,
  input  logic [WORD_W-1:0]    s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 aes_start,
  output logic [AES_BLK_W-1:0] aes_plain_text,
  output logic [AES_BLK_W-1:0] aes_cipher_key,
  input  logic                 aes_done,
  input  logic [AES_BLK_W-1:0] aes_cipher_text,
  output logic                 busy,
  output logic [15:0]          blk_count,
  output logic                 err
);

  localparam int unsigned NW = num_words(WORD_W);
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  feeder_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic [15:0]          blk_count_q, blk_count_d;
  logic [AES_BLK_W-1:0] drain_data;
  logic                 s_fire, m_fire, capture, timeout;

  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;
  // Only the first done cycle inside WAIT counts; WAIT is left on that same edge.
  assign capture = (state_q == StWait) & aes_done;

`ifdef AES_FEEDER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;

  assign timeout = (state_q == StWait) & ~aes_done & (tmo_cnt_q == TIMEOUT_CYC - 1);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q | timeout;
    if (state_q == StStart) begin
      tmo_cnt_d = '0;
    end else if (state_q == StWait) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StGather;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StGather: if (s_fire && idx_q == LAST_IDX) state_d = StStart;
      StStart:  state_d = StWait;
      StWait: begin
        if (capture) begin
          state_d = StDrain;
        end else if (timeout) begin
          state_d = StGather;
        end
      end
      StDrain:  if (m_fire && idx_q == LAST_IDX) state_d = StGather;
      default:  state_d = StGather;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    s_ready   = 1'b0;
    aes_start = 1'b0;
    m_valid   = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StGather: s_ready = 1'b1;
      StStart: begin
        aes_start = 1'b1;
        busy      = 1'b1;
      end
      StWait:   busy = 1'b1;
      StDrain: begin
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      default:  s_ready = 1'b0;
    endcase
  end

  // Word index is shared: counts accepted words in GATHER, sent words in DRAIN.
  always_comb begin
    idx_d       = idx_q;
    key_d       = key_q;
    blk_count_d = blk_count_q;
    if (s_fire || m_fire) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (key_load && (state_q == StGather || state_q == StDrain)) begin
      key_d = key_in;
    end
    if (capture) begin
      blk_count_d = blk_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      key_q       <= '0;
      blk_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      key_q       <= key_d;
      blk_count_q <= blk_count_d;
    end
  end

  aes_word_shifter #(
    .WORD_W(WORD_W)
  ) u_gather (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_data('0),
    .shift    (s_fire),
    .shift_in (s_data),
    .data     (aes_plain_text)
  );

  aes_word_shifter #(
    .WORD_W(WORD_W)
  ) u_drain (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_data(aes_cipher_text),
    .shift    (m_fire),
    .shift_in ('0),
    .data     (drain_data)
  );

  assign m_data         = drain_data[AES_BLK_W-1 -: WORD_W];
  assign m_last         = m_valid & (idx_q == LAST_IDX);
  assign aes_cipher_key = key_q;
  assign blk_count      = blk_count_q;

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Self-checking bench for aes_stream_feeder. The bench stands in for the AES core: it checks
// the plaintext/key presented at start and returns a ciphertext of its own choosing, then
// expects that ciphertext back as a word stream. Honours AES_FEEDER_TIMEOUT_EN.
module tb_aes_stream_feeder;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned NW          = 128 / WORD_W;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic               clk, rst;
  logic [127:0]       key_in;
  logic               key_load;
  logic               s_valid;
  logic [WORD_W-1:0]  s_data;
  logic               s_ready;
  logic               m_valid;
  logic [WORD_W-1:0]  m_data;
  logic               m_last;
  logic               m_ready;
  logic               aes_start;
  logic [127:0]       aes_plain_text;
  logic [127:0]       aes_cipher_key;
  logic               aes_done;
  logic [127:0]       aes_cipher_text;
  logic               busy;
  logic [15:0]        blk_count;
  logic               err;

  aes_stream_feeder #(
    .WORD_W     (WORD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_in         (key_in),
    .key_load       (key_load),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .aes_start      (aes_start),
    .aes_plain_text (aes_plain_text),
    .aes_cipher_key (aes_cipher_key),
    .aes_done       (aes_done),
    .aes_cipher_text(aes_cipher_text),
    .busy           (busy),
    .blk_count      (blk_count),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [127:0] mdl_key;
  logic [15:0]  mdl_blk;
  logic         mdl_err;
  int           mdl_starts;
  int           seen_starts = 0;

  always @(negedge clk) if (aes_start) seen_starts++;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_state();
    check_val("rst_s_ready", s_ready, 1'b1);
    check_val("rst_m_valid", m_valid, 1'b0);
    check_val("rst_m_data", m_data, '0);
    check_val("rst_m_last", m_last, 1'b0);
    check_val("rst_aes_start", aes_start, 1'b0);
    check_val("rst_plain", aes_plain_text, '0);
    check_val("rst_key", aes_cipher_key, '0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_blk_count", blk_count, '0);
    check_val("rst_err", err, 1'b0);
  endtask

  task automatic idle_check();
    check_val("idle_s_ready", s_ready, 1'b1);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_m_valid", m_valid, 1'b0);
    check_val("idle_blk_count", blk_count, mdl_blk);
    check_val("idle_err", err, mdl_err);
  endtask

  task automatic load_key_idle(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    mdl_key  = k;
    @(negedge clk);
    key_load = 1'b0;
    check_val("key_load_idle", aes_cipher_key, mdl_key);
  endtask

  // Sends one block; optional key load with word key_at, spurious done before word spur_at.
  task automatic send_block(input logic [127:0] blk, input bit gaps, input int key_at,
                            input int spur_at);
    for (int i = 0; i < int'(NW); i++) begin
      if (i == spur_at) begin
        s_valid         = 1'b0;
        aes_done        = 1'b1;
        aes_cipher_text = rand128();
        repeat (2) begin
          @(negedge clk);
          check_val("spur_s_ready", s_ready, 1'b1);
          check_val("spur_busy", busy, 1'b0);
          check_val("spur_blk_count", blk_count, mdl_blk);
        end
        aes_done = 1'b0;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = blk[127 - WORD_W*i -: WORD_W];
      if (i == key_at) begin
        key_load = 1'b1;
        key_in   = rand128();
        mdl_key  = key_in;
      end
      if (!s_ready) check_val("gather_s_ready", s_ready, 1'b1);
      @(negedge clk);
      s_valid  = 1'b0;
      key_load = 1'b0;
    end
  endtask

  // Called at the negedge right after the last word was accepted; returns in WAIT cycle 0.
  task automatic expect_start(input logic [127:0] blk);
    mdl_starts++;
    check_val("start_pulse", aes_start, 1'b1);
    check_val("start_s_ready", s_ready, 1'b0);
    check_val("start_plain", aes_plain_text, blk);
    check_val("start_key", aes_cipher_key, mdl_key);
    @(negedge clk);
    check_val("start_one_cycle", aes_start, 1'b0);
    check_val("wait_busy", busy, 1'b1);
  endtask

  task automatic core_respond(input logic [127:0] blk, input logic [127:0] cipher,
                              input int delay, input int hold, input bit wait_key);
    for (int c = 0; c < delay; c++) begin
      if (wait_key && c == 0) begin
        key_load = 1'b1;
        key_in   = rand128();
      end
      if (c == 2) key_load = 1'b0;
      @(negedge clk);
      if (c == delay - 1) begin
        check_val("wait_key_kept", aes_cipher_key, mdl_key);
        check_val("wait_plain_kept", aes_plain_text, blk);
        check_val("wait_s_ready", s_ready, 1'b0);
        check_val("wait_m_valid", m_valid, 1'b0);
      end
    end
    key_load        = 1'b0;
    aes_done        = 1'b1;
    aes_cipher_text = cipher;
    m_ready         = 1'b0;
    mdl_blk         = mdl_blk + 16'd1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == 0) aes_cipher_text = rand128();
      check_val("done_m_valid", m_valid, 1'b1);
      check_val("done_m_data", m_data, cipher[127 -: WORD_W]);
      check_val("done_blk_count", blk_count, mdl_blk);
    end
    aes_done = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle starting low, 2: random
  task automatic drain_block(input logic [127:0] cipher, input int mode, input bit drain_key);
    int  i = 0;
    int  n = 0;
    bit  tog = 1'b0;
    bit  mr;
    while (i < int'(NW) && n < 200) begin
      check_val("drain_m_valid", m_valid, 1'b1);
      check_val("drain_m_data", m_data, cipher[127 - WORD_W*i -: WORD_W]);
      check_val("drain_m_last", m_last, (i == int'(NW) - 1));
      check_val("drain_s_ready", s_ready, 1'b0);
      mr  = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      m_ready = mr;
      if (drain_key && n == 1) begin
        key_load = 1'b1;
        key_in   = rand128();
        mdl_key  = key_in;
      end else begin
        key_load = 1'b0;
      end
      @(negedge clk);
      if (mr) i++;
      n++;
    end
    m_ready  = 1'b0;
    key_load = 1'b0;
    if (i < int'(NW)) check_val("drain_words_sent", i, NW);
    idle_check();
    check_val("drain_key_now", aes_cipher_key, mdl_key);
  endtask

  task automatic run_block(input logic [127:0] blk, input logic [127:0] cipher,
                           input int delay, input int hold, input bit wait_key,
                           input int mode, input bit drain_key, input bit gaps,
                           input int key_at, input int spur_at);
    send_block(blk, gaps, key_at, spur_at);
    expect_start(blk);
    core_respond(blk, cipher, delay, hold, wait_key);
    drain_block(cipher, mode, drain_key);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [127:0] blk;
    rst             = 1'b0;
    key_in          = '0;
    key_load        = 1'b0;
    s_valid         = 1'b0;
    s_data          = '0;
    m_ready         = 1'b0;
    aes_done        = 1'b0;
    aes_cipher_text = '0;
    mdl_key         = '0;
    mdl_blk         = '0;
    mdl_err         = 1'b0;
    mdl_starts      = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_check();

    // FIPS-197 C.1 vector; the bench plays the core
    load_key_idle(128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              10, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
    check_val("fips_blk_count", blk_count, 16'd1);

    // Backpressure toggling during DRAIN
    run_block(rand128(), rand128(), 4, 1, 1'b0, 1, 1'b0, 1'b0, -1, -1);
    // Done held high 5 cycles
    run_block(rand128(), rand128(), 3, 5, 1'b0, 0, 1'b0, 1'b0, -1, -1);
    // Spurious done while idle and mid-gather
    run_block(rand128(), rand128(), 2, 1, 1'b0, 0, 1'b0, 1'b1, -1, 0);
    run_block(rand128(), rand128(), 2, 1, 1'b0, 2, 1'b0, 1'b0, -1, 2);
    // Key load in WAIT is dropped; key load in DRAIN is used by the next block
    run_block(rand128(), rand128(), 6, 1, 1'b1, 0, 1'b1, 1'b0, -1, -1);
    run_block(rand128(), rand128(), 3, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
    // Key load together with a word accept
    run_block(rand128(), rand128(), 3, 1, 1'b0, 0, 1'b0, 1'b0, 2, -1);

`ifdef AES_FEEDER_TIMEOUT_EN
    blk = rand128();
    send_block(blk, 1'b0, -1, -1);
    expect_start(blk);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check_val("tmo_last_wait_busy", busy, 1'b1);
    check_val("tmo_last_wait_err", err, 1'b0);
    @(negedge clk);
    mdl_err = 1'b1;
    idle_check();
    run_block(rand128(), rand128(), 5, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
`else
    // Without the timeout option WAIT holds well past TIMEOUT_CYC
    run_block(rand128(), rand128(), 100, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
`endif

    // Randomized blocks
    for (int b = 0; b < 12; b++) begin
      run_block(rand128(), rand128(), $urandom_range(1, 20), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'b1, ($urandom_range(0, 1) != 0) ? $urandom_range(0, NW - 1) : -1, -1);
    end
    check_val("blk_count_total", blk_count, mdl_blk);

    // Reset in WAIT drops the block; the next words form a fresh one
    blk = rand128();
    send_block(blk, 1'b0, -1, -1);
    expect_start(blk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state();
    mdl_key = '0;
    mdl_blk = '0;
    mdl_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block(rand128(), rand128(), 4, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
    check_val("post_rst_blk_count", blk_count, 16'd1);
    check_val("start_pulse_total", seen_starts, mdl_starts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
